// File: rtl/dfr_phase_sequencer.sv
// Steps a datapath through INIT, TRAIN and TEST phases sample by sample, one step per handshake.
// Counters and state are registered; step_valid/sample_done also see abort and step_ready in the same cycle.
module dfr_phase_sequencer (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] num_init_samples,
    input  logic [31:0] num_train_samples,
    input  logic [31:0] num_test_samples,
    input  logic [31:0] num_steps_per_sample,
    input  logic        step_ready,
    output logic        busy,
    output logic [1:0]  phase,
    output logic        step_valid,
    output logic [31:0] sample_idx,
    output logic [31:0] step_idx,
    output logic [29:0] sample_addr,
    output logic        sample_done,
    output logic        done,
    output logic        aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_TRAIN,
        S_TEST,
        S_DONE
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic [1:0]  nxt_phase;
    logic [31:0] cfg_init;
    logic [31:0] cfg_train;
    logic [31:0] cfg_test;
    logic [31:0] cfg_steps;
    logic [31:0] cur_n;
    logic [31:0] nxt_n;
    logic        step_req;
    logic        in_phase;
    logic        hs;
    logic        last_step;
    logic        last_sample;
    logic        phase_end;

    always_comb begin
        cur_n     = '0;
        nxt_n     = '0;
        nxt_state = S_IDLE;
        nxt_phase = 2'd0;
        case (state)
            S_INIT: begin
                cur_n     = cfg_init;
                nxt_n     = cfg_train;
                nxt_state = S_TRAIN;
                nxt_phase = 2'd2;
            end
            S_TRAIN: begin
                cur_n     = cfg_train;
                nxt_n     = cfg_test;
                nxt_state = S_TEST;
                nxt_phase = 2'd3;
            end
            S_TEST: begin
                cur_n     = cfg_test;
                nxt_state = S_DONE;
            end
            default: ;
        endcase
    end

    assign in_phase    = (state == S_INIT) || (state == S_TRAIN) || (state == S_TEST);
    // Abort withdraws the request in the same cycle, so the datapath never sees an uncounted handshake.
    assign step_valid  = step_req && !abort;
    assign hs          = step_valid && step_ready;
    assign last_step   = (step_idx == cfg_steps - 32'd1);
    assign last_sample = (sample_idx == cur_n - 32'd1);
    assign sample_done = hs && last_step;
    // A phase with no request pending is empty and lasts a single cycle.
    assign phase_end   = in_phase && (!step_req || (hs && last_step && last_sample));

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            phase       <= 2'd0;
            step_req    <= 1'b0;
            sample_idx  <= '0;
            step_idx    <= '0;
            sample_addr <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            cfg_init    <= '0;
            cfg_train   <= '0;
            cfg_test    <= '0;
            cfg_steps   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                aborted <= 1'b1;
                if (state != S_IDLE) begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    phase    <= 2'd0;
                    step_req <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state       <= S_INIT;
                            busy        <= 1'b1;
                            phase       <= 2'd1;
                            aborted     <= 1'b0;
                            sample_idx  <= '0;
                            step_idx    <= '0;
                            sample_addr <= '0;
                            cfg_init    <= num_init_samples;
                            cfg_train   <= num_train_samples;
                            cfg_test    <= num_test_samples;
                            cfg_steps   <= num_steps_per_sample;
                            step_req    <= (num_init_samples != '0) && (num_steps_per_sample != '0);
                        end
                    end
                    S_INIT, S_TRAIN, S_TEST: begin
                        if (hs) begin
                            if (last_step) begin
                                step_idx    <= '0;
                                sample_idx  <= sample_idx + 32'd1;
                                sample_addr <= sample_addr + 30'd1;
                            end else begin
                                step_idx <= step_idx + 32'd1;
                            end
                        end
                        if (phase_end) begin
                            state      <= nxt_state;
                            phase      <= nxt_phase;
                            sample_idx <= '0;
                            step_idx   <= '0;
                            step_req   <= (nxt_n != '0) && (cfg_steps != '0);
                            done       <= (nxt_state == S_DONE);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Directed bench for dfr_phase_sequencer: a per-step schedule model checked every cycle, plus literal run checks.
module tb_dfr_phase_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        step_ready = 1'b0;
    logic [31:0] n_init = '0;
    logic [31:0] n_train = '0;
    logic [31:0] n_test = '0;
    logic [31:0] n_steps = '0;

    logic        busy;
    logic [1:0]  phase;
    logic        step_valid;
    logic [31:0] sample_idx;
    logic [31:0] step_idx;
    logic [29:0] sample_addr;
    logic        sample_done;
    logic        done;
    logic        aborted;

    dfr_phase_sequencer dut (
        .S_AXI_ACLK          (clk),
        .S_AXI_ARESETN       (rstn),
        .start               (start),
        .abort               (abort),
        .num_init_samples    (n_init),
        .num_train_samples   (n_train),
        .num_test_samples    (n_test),
        .num_steps_per_sample(n_steps),
        .step_ready          (step_ready),
        .busy                (busy),
        .phase               (phase),
        .step_valid          (step_valid),
        .sample_idx          (sample_idx),
        .step_idx            (step_idx),
        .sample_addr         (sample_addr),
        .sample_done         (sample_done),
        .done                (done),
        .aborted             (aborted)
    );

    always #5 clk = ~clk;

    // One entry per busy cycle the run must spend (a step awaiting handshake, an empty phase, or DONE).
    typedef struct {
        logic [1:0]  ph;
        bit          is_step;
        bit          is_done;
        int unsigned sidx;
        int unsigned tidx;
        logic [29:0] addr;
        bit          last;
    } slot_t;

    slot_t       q[$];
    int unsigned m_sidx = 0;
    int unsigned m_tidx = 0;
    logic [29:0] m_addr = '0;
    bit          m_aborted = 1'b0;
    bit          model_valid = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int sd_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int ph_log[$];
    int addr_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic build_schedule();
        slot_t       s;
        logic [29:0] a = '0;
        int unsigned cnt;
        q.delete();
        for (int p = 1; p <= 3; p++) begin
            cnt = (p == 1) ? n_init : (p == 2) ? n_train : n_test;
            if (n_steps == 0) cnt = 0;
            s.ph = 2'(p);
            s.is_done = 1'b0;
            if (cnt == 0) begin
                s.is_step = 1'b0; s.sidx = 0; s.tidx = 0; s.addr = a; s.last = 1'b0;
                q.push_back(s);
            end else begin
                for (int unsigned si = 0; si < cnt; si++) begin
                    for (int unsigned ti = 0; ti < n_steps; ti++) begin
                        s.is_step = 1'b1; s.sidx = si; s.tidx = ti; s.addr = a;
                        s.last = (ti == n_steps - 1);
                        q.push_back(s);
                    end
                    a = a + 30'd1;
                end
            end
        end
        s.ph = 2'd0; s.is_step = 1'b0; s.is_done = 1'b1; s.sidx = 0; s.tidx = 0; s.addr = a; s.last = 1'b0;
        q.push_back(s);
    endtask

    always @(negedge clk) begin : monitor
        slot_t       h;
        logic        e_busy, e_sv, e_sd, e_done;
        logic [1:0]  e_ph;
        int unsigned e_sidx, e_tidx;
        logic [29:0] e_addr;
        cyc++;
        if (model_valid) begin
            if (q.size() == 0) begin
                e_busy = 0; e_ph = 0; e_sv = 0; e_sd = 0; e_done = 0;
                e_sidx = m_sidx; e_tidx = m_tidx; e_addr = m_addr;
            end else begin
                h = q[0];
                e_busy = 1; e_ph = h.ph; e_done = h.is_done;
                e_sv = h.is_step && !abort;
                e_sd = h.is_step && step_ready && h.last && !abort;
                e_sidx = h.sidx; e_tidx = h.tidx; e_addr = h.addr;
            end
            chk("busy", 64'(busy), 64'(e_busy));
            chk("phase", 64'(phase), 64'(e_ph));
            chk("step_valid", 64'(step_valid), 64'(e_sv));
            chk("sample_done", 64'(sample_done), 64'(e_sd));
            chk("done", 64'(done), 64'(e_done));
            chk("sample_idx", 64'(sample_idx), 64'(e_sidx));
            chk("step_idx", 64'(step_idx), 64'(e_tidx));
            chk("sample_addr", 64'(sample_addr), 64'(e_addr));
            chk("aborted", 64'(aborted), 64'(m_aborted));
        end
        if (step_valid === 1'b1 && step_ready) hs_cnt++;
        if (sample_done === 1'b1) begin
            sd_cnt++;
            ph_log.push_back(int'(phase));
            addr_log.push_back(int'(sample_addr));
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (start && !abort && rstn && busy === 1'b0) start_cyc = cyc;

        // Advance the model to the state that the coming rising edge must produce.
        if (!rstn) begin
            q.delete(); m_sidx = 0; m_tidx = 0; m_addr = '0; m_aborted = 0;
            model_valid = 1'b1;
        end else if (abort) begin
            if (q.size() != 0) begin
                h = q[0]; m_sidx = h.sidx; m_tidx = h.tidx; m_addr = h.addr;
                q.delete();
            end
            m_aborted = 1'b1;
        end else if (q.size() == 0) begin
            if (start) begin
                build_schedule();
                m_aborted = 1'b0;
            end
        end else begin
            h = q[0];
            if (!h.is_step || step_ready) begin
                m_sidx = h.sidx; m_tidx = h.tidx; m_addr = h.addr;
                void'(q.pop_front());
            end
        end
    end

    int b_hs, b_sd, b_busy, b_done, b_log;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_hs = hs_cnt; b_sd = sd_cnt; b_busy = busy_cnt; b_done = done_cnt; b_log = ph_log.size();
    endtask

    task automatic cfg(input int i, input int tr, input int te, input int st);
        n_init = 32'(i); n_train = 32'(tr); n_test = 32'(te); n_steps = 32'(st);
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
            else if (toggle) step_ready = ~step_ready;
        end
        step();
        chk("run_reached_done", 64'(seen), 64'(1));
    endtask

    task automatic wait_phase(input logic [1:0] ph, input logic [31:0] tidx, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (phase === ph && step_idx === tidx) seen = 1'b1;
        end
        chk("phase_reached", 64'(seen), 64'(1));
    endtask

    initial begin
        int exp_ph[4];
        int exp_addr[4];
        exp_ph = '{1, 2, 2, 3};
        exp_addr = '{0, 1, 2, 3};

        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_phase", 64'(phase), 64'(0));
        chk("rst_addr", 64'(sample_addr), 64'(0));
        chk("rst_aborted", 64'(aborted), 64'(0));
        rstn = 1'b1;
        step();

        // Baseline run, always ready.
        snap();
        cfg(1, 2, 1, 3); step_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        wait_done(60, 1'b0);
        chk("base_handshakes", 64'(hs_cnt - b_hs), 64'(12));
        chk("base_sample_done", 64'(sd_cnt - b_sd), 64'(4));
        chk("base_done_offset", 64'(done_cyc - start_cyc), 64'(13));
        chk("base_done_pulses", 64'(done_cnt - b_done), 64'(1));
        for (int i = 0; i < 4; i++) begin
            chk("base_sample_phase", 64'(ph_log[b_log + i]), 64'(exp_ph[i]));
            chk("base_sample_addr", 64'(addr_log[b_log + i]), 64'(exp_addr[i]));
        end

        // Stalling ready, config changed and start re-pulsed mid-run.
        snap();
        step_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0; cfg(5, 5, 5, 5); step_ready = 1'b0;
        step(); start = 1'b1; step_ready = 1'b1;
        step(); start = 1'b0; step_ready = 1'b0;
        wait_done(100, 1'b1);
        chk("stall_handshakes", 64'(hs_cnt - b_hs), 64'(12));
        chk("stall_sample_done", 64'(sd_cnt - b_sd), 64'(4));

        // Empty TRAIN phase.
        snap();
        cfg(1, 0, 1, 2); step_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        wait_done(40, 1'b0);
        chk("empty_train_handshakes", 64'(hs_cnt - b_hs), 64'(4));
        chk("empty_train_busy", 64'(busy_cnt - b_busy), 64'(6));
        chk("empty_train_done_offset", 64'(done_cyc - start_cyc), 64'(6));

        // Zero steps per sample.
        snap();
        cfg(2, 2, 2, 0); start = 1'b1;
        step(); start = 1'b0;
        wait_done(20, 1'b0);
        chk("zero_steps_busy", 64'(busy_cnt - b_busy), 64'(4));
        chk("zero_steps_handshakes", 64'(hs_cnt - b_hs), 64'(0));
        chk("zero_steps_done_offset", 64'(done_cyc - start_cyc), 64'(4));

        // Abort on a would-be handshake in TRAIN.
        snap();
        cfg(1, 2, 1, 3); step_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        wait_phase(2'd2, 32'd1, 30);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_sticky", 64'(aborted), 64'(1));
        chk("abort_step_idx", 64'(step_idx), 64'(1));
        chk("abort_sample_idx", 64'(sample_idx), 64'(0));
        chk("abort_sample_addr", 64'(sample_addr), 64'(1));
        repeat (15) step();
        chk("abort_no_done", 64'(done_cnt - b_done), 64'(0));
        start = 1'b1;
        step(); start = 1'b0;
        chk("restart_clears_aborted", 64'(aborted), 64'(0));
        chk("restart_busy", 64'(busy), 64'(1));
        wait_done(40, 1'b0);

        // Start and abort together in IDLE.
        start = 1'b1; abort = 1'b1;
        step(); start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'(0));
        step();

        // Reset in the middle of TEST.
        snap();
        start = 1'b1;
        step(); start = 1'b0;
        wait_phase(2'd3, 32'd1, 30);
        rstn = 1'b0;
        step(); rstn = 1'b1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_phase", 64'(phase), 64'(0));
        chk("midrst_addr", 64'(sample_addr), 64'(0));
        chk("midrst_step_valid", 64'(step_valid), 64'(0));
        repeat (5) step();
        chk("midrst_no_done", 64'(done_cnt - b_done), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
